// File: rtl/lexer_pkg.sv
// Shared types for the token lexer: token codes, FSM state encoding, char classes.
// HEX_LITERAL_EN adds the hex-prefix states (S_HEXP, S_HEX) to the state encoding.
package lexer_pkg;

    typedef enum logic [1:0] {
        TOK_IDENT = 2'd0,
        TOK_DEC   = 2'd1,
        TOK_HEX   = 2'd2,
        TOK_ERR   = 2'd3
    } tok_type_e;

`ifdef HEX_LITERAL_EN
    typedef enum logic [2:0] {
        S_IDLE, S_IDENT, S_DEC, S_ZERO, S_HEXP, S_HEX, S_ERR
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_IDENT, S_DEC, S_ZERO, S_ERR
    } state_e;
`endif

    // CC_HEXALPHA is a letter that is also a hex digit (a-f, A-F).
    typedef enum logic [1:0] {
        CC_DELIM    = 2'd0,
        CC_LETTER   = 2'd1,
        CC_DIGIT    = 2'd2,
        CC_HEXALPHA = 2'd3
    } char_class_e;

    function automatic char_class_e classify(input logic [6:0] c, input logic hi);
        char_class_e cc;
        cc = CC_DELIM;
        if (!hi) begin
            if ((c >= 7'h61 && c <= 7'h66) || (c >= 7'h41 && c <= 7'h46))
                cc = CC_HEXALPHA;
            else if ((c >= 7'h61 && c <= 7'h7A) || (c >= 7'h41 && c <= 7'h5A) || c == 7'h5F)
                cc = CC_LETTER;
            else if (c >= 7'h30 && c <= 7'h39)
                cc = CC_DIGIT;
        end
        return cc;
    endfunction

endpackage

// File: rtl/token_lexer_fsm_if.sv
// Character-in / token-out bundle of the lexer; master drives characters, slave is the lexer.
interface token_lexer_fsm_if #(
    parameter int CHAR_W  = 8,
    parameter int MAX_LEN = 32
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic              in_valid;
    logic [CHAR_W-1:0] in_char;
    logic              in_last;
    logic              id_now;
    logic              tok_valid;
    logic [1:0]        tok_type;
    logic [LEN_W-1:0]  tok_len;

    modport master (
        output in_valid, in_char, in_last,
        input  id_now, tok_valid, tok_type, tok_len
    );

    modport slave (
        input  in_valid, in_char, in_last,
        output id_now, tok_valid, tok_type, tok_len
    );
endinterface

// File: rtl/char_classifier.sv
// Combinational character classifier: any bit at or above bit 7 makes the char a delimiter.
module char_classifier
    import lexer_pkg::*;
#(
    parameter int CHAR_W = 8
) (
    input  logic [CHAR_W-1:0] in_char,
    output char_class_e       cls,
    output logic              is_hex_digit,
    output logic              is_x
);
    logic hi;

    assign hi           = |in_char[CHAR_W-1:7];
    assign cls          = classify(in_char[6:0], hi);
    assign is_hex_digit = (cls == CC_DIGIT) || (cls == CC_HEXALPHA);
    assign is_x         = !hi && (in_char[6:0] == 7'h78 || in_char[6:0] == 7'h58);
endmodule

// File: rtl/token_lexer_fsm.sv
// Streaming lexer: groups [A-Za-z0-9_] runs into tokens with saturating length.
// Define HEX_LITERAL_EN to recognise 0x/0X hex literals as TOK_HEX.
module token_lexer_fsm
    import lexer_pkg::*;
#(
    parameter int CHAR_W  = 8,
    parameter int MAX_LEN = 32
) (
    input logic              clk,
    input logic              rst_n,
    token_lexer_fsm_if.slave bus
);
    localparam int               LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_e           state_q, state_d, run_state;
    logic [LEN_W-1:0] len_q, len_d, run_len;
    logic             id_now_q, id_now_d;
    logic             tok_valid_q, tok_valid_d;
    tok_type_e        tok_type_q, tok_type_d;
    logic [LEN_W-1:0] tok_len_q, tok_len_d;

    char_class_e cls;
    logic        is_hex_digit, is_x, is_letter, is_digit, is_zero;

    char_classifier #(.CHAR_W(CHAR_W)) u_classifier (
        .in_char      (bus.in_char),
        .cls          (cls),
        .is_hex_digit (is_hex_digit),
        .is_x         (is_x)
    );

    assign is_letter = (cls == CC_LETTER) || (cls == CC_HEXALPHA);
    assign is_digit  = is_hex_digit && (cls != CC_HEXALPHA);
    assign is_zero   = is_digit && (bus.in_char[3:0] == 4'd0);

    function automatic tok_type_e class_of(input state_e s);
        tok_type_e t;
        case (s)
            S_IDENT:         t = TOK_IDENT;
            S_DEC, S_ZERO:   t = TOK_DEC;
`ifdef HEX_LITERAL_EN
            S_HEX:           t = TOK_HEX;
`endif
            default:         t = TOK_ERR;
        endcase
        return t;
    endfunction

    // Where the run goes if the current char is a run char (not a delimiter).
    always_comb begin
        run_state = S_ERR;
        case (state_q)
            S_IDLE: begin
                if (is_letter)    run_state = S_IDENT;
                else if (is_zero) run_state = S_ZERO;
                else              run_state = S_DEC;
            end
            S_IDENT: run_state = S_IDENT;
            S_DEC:   run_state = is_digit ? S_DEC : S_ERR;
            S_ZERO: begin
                if (is_digit)  run_state = S_DEC;
`ifdef HEX_LITERAL_EN
                else if (is_x) run_state = S_HEXP;
`else
                else if (is_x) run_state = S_ERR;
`endif
                else           run_state = S_ERR;
            end
`ifdef HEX_LITERAL_EN
            S_HEXP, S_HEX: run_state = is_hex_digit ? S_HEX : S_ERR;
`endif
            default: run_state = S_ERR;
        endcase

        run_len = len_q + LEN_W'(1);
        if (len_q == LEN_MAX) begin
            run_state = S_ERR;
            run_len   = len_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        id_now_d    = id_now_q;
        tok_valid_d = 1'b0;
        tok_type_d  = tok_type_q;
        tok_len_d   = tok_len_q;

        if (bus.in_valid) begin
            if (cls == CC_DELIM) begin
                state_d  = S_IDLE;
                len_d    = '0;
                id_now_d = 1'b0;
                if (state_q != S_IDLE) begin
                    tok_valid_d = 1'b1;
                    tok_type_d  = class_of(state_q);
                    tok_len_d   = len_q;
                end
            end else begin
                state_d  = run_state;
                len_d    = run_len;
                id_now_d = (run_state == S_IDENT);
                // A final run char closes the token as if a delimiter followed it.
                if (bus.in_last) begin
                    tok_valid_d = 1'b1;
                    tok_type_d  = class_of(run_state);
                    tok_len_d   = run_len;
                    state_d     = S_IDLE;
                    len_d       = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            id_now_q    <= 1'b0;
            tok_valid_q <= 1'b0;
            tok_type_q  <= TOK_IDENT;
            tok_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            id_now_q    <= id_now_d;
            tok_valid_q <= tok_valid_d;
            tok_type_q  <= tok_type_d;
            tok_len_q   <= tok_len_d;
        end
    end

    assign bus.id_now    = id_now_q;
    assign bus.tok_valid = tok_valid_q;
    assign bus.tok_type  = tok_type_q;
    assign bus.tok_len   = tok_len_q;
endmodule

// File: tb/tb_token_lexer_fsm.sv
// Self-checking bench for token_lexer_fsm: directed table, corner sequences, random vs. string model.
// Expectations follow HEX_LITERAL_EN when the bench is built with it.
module tb_token_lexer_fsm;
    localparam int CHAR_W  = 8;
    localparam int MAX_LEN = 32;
    localparam int T_IDENT = 0, T_DEC = 1, T_HEX = 2, T_ERR = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    token_lexer_fsm_if #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN)) bus ();

    token_lexer_fsm #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the current run as a list of characters, classified as a whole.
    byte unsigned run[$];
    bit m_id = 1'b0;
    bit m_tv = 1'b0;
    int m_type = 0;
    int m_len = 0;

    int obs_pulses = 0;
    int obs_type = -1;
    int obs_len = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic bit is_letter_c(input byte unsigned c);
        return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || c == "_";
    endfunction

    function automatic bit is_digit_c(input byte unsigned c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic bit is_hexd_c(input byte unsigned c);
        return is_digit_c(c) || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
    endfunction

    function automatic int classify_run();
        int n;
        n = run.size();
        if (n > MAX_LEN) return T_ERR;
        if (is_letter_c(run[0])) return T_IDENT;
`ifdef HEX_LITERAL_EN
        if (n >= 2 && run[0] == "0" && (run[1] == "x" || run[1] == "X")) begin
            if (n == 2) return T_ERR;
            for (int i = 2; i < n; i++)
                if (!is_hexd_c(run[i])) return T_ERR;
            return T_HEX;
        end
`endif
        for (int i = 0; i < n; i++)
            if (!is_digit_c(run[i])) return T_ERR;
        return T_DEC;
    endfunction

    function automatic void emit_run();
        m_tv   = 1'b1;
        m_type = classify_run();
        m_len  = (run.size() > MAX_LEN) ? MAX_LEN : run.size();
        run.delete();
    endfunction

    function automatic void model_step(input bit v, input byte unsigned c, input bit last);
        m_tv = 1'b0;
        if (v) begin
            if (!(is_letter_c(c) || is_digit_c(c))) begin
                m_id = 1'b0;
                if (run.size() > 0) emit_run();
            end else begin
                run.push_back(c);
                m_id = (run.size() <= MAX_LEN) && is_letter_c(run[0]);
                if (last) emit_run();
            end
        end
    endfunction

    task automatic drive(input bit v, input byte unsigned c, input bit last);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_char  = c;
        bus.in_last  = last;
        model_step(v, c, last);
        @(posedge clk);
        #1;
        if (bus.tok_valid) begin
            obs_pulses++;
            obs_type = int'(bus.tok_type);
            obs_len  = int'(bus.tok_len);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " tok_valid"}, int'(bus.tok_valid), int'(m_tv));
        if (m_tv) begin
            chk({tag, " tok_type"}, int'(bus.tok_type), m_type);
            chk({tag, " tok_len"}, int'(bus.tok_len), m_len);
        end
        chk({tag, " id_now"}, int'(bus.id_now), int'(m_id));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        run.delete();
        m_id = 1'b0;
        m_tv = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " rst id_now"}, int'(bus.id_now), 0);
        chk({tag, " rst tok_valid"}, int'(bus.tok_valid), 0);
        chk({tag, " rst tok_type"}, int'(bus.tok_type), 0);
        chk({tag, " rst tok_len"}, int'(bus.tok_len), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_str(input string tag, input string s, input bit last_on_final, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            drive(1'b1, s[i], last_on_final && (i == s.len() - 1));
            check_model(tag);
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 8'h00, 1'b0);
                check_model(tag);
            end
        end
    endtask

    task automatic send_rep(input string tag, input byte unsigned c, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, c, 1'b0);
            check_model(tag);
        end
    endtask

    task automatic expect_token(input string tag, input int pulses, input int ty, input int len);
        chk({tag, " pulses"}, obs_pulses, pulses);
        chk({tag, " type"}, obs_type, ty);
        chk({tag, " len"}, obs_len, len);
    endtask

    function automatic byte unsigned rand_char();
        int r;
        r = $urandom_range(0, 99);
        if (r < 20) return 8'("a" + $urandom_range(0, 25));
        if (r < 28) return 8'("A" + $urandom_range(0, 25));
        if (r < 30) return "_";
        if (r < 48) return 8'("0" + $urandom_range(0, 9));
        if (r < 58) return "0";
        if (r < 64) return ($urandom_range(0, 1) != 0) ? "x" : "X";
        if (r < 70) return 8'("a" + $urandom_range(0, 5));
        if (r < 84) return " ";
        if (r < 92) return ";";
        return 8'(8'h80 + $urandom_range(0, 127));
    endfunction

    typedef struct {
        bit           v;
        byte unsigned c;
        bit           last;
        bit           tv;
        int           ty;
        int           len;
        bit           id;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        bus.in_last  = 1'b0;
        tbl[0] = '{1'b1, "a", 1'b0, 1'b0, 0, 0, 1'b1};
        tbl[1] = '{1'b1, "b", 1'b0, 1'b0, 0, 0, 1'b1};
        tbl[2] = '{1'b1, "3", 1'b0, 1'b0, 0, 0, 1'b1};
        tbl[3] = '{1'b1, "2", 1'b0, 1'b0, 0, 0, 1'b1};
        tbl[4] = '{1'b1, ")", 1'b0, 1'b1, T_IDENT, 4, 1'b0};
        tbl[5] = '{1'b1, "1", 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[6] = '{1'b1, "e", 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[7] = '{1'b1, "1", 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[8] = '{1'b1, "e", 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[9] = '{1'b1, "6", 1'b1, 1'b1, T_ERR, 5, 1'b0};

        repeat (2) @(posedge clk);
        do_reset("init");

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].c, tbl[i].last);
            chk($sformatf("tbl%0d tok_valid", i), int'(bus.tok_valid), int'(tbl[i].tv));
            if (tbl[i].tv) begin
                chk($sformatf("tbl%0d tok_type", i), int'(bus.tok_type), tbl[i].ty);
                chk($sformatf("tbl%0d tok_len", i), int'(bus.tok_len), tbl[i].len);
            end
            chk($sformatf("tbl%0d id_now", i), int'(bus.id_now), int'(tbl[i].id));
        end

        obs_pulses = 0;
        send_str("hex", "0x1F ", 1'b0, 0);
`ifdef HEX_LITERAL_EN
        expect_token("hex", 1, T_HEX, 4);
`else
        expect_token("hex", 1, T_ERR, 4);
`endif

        obs_pulses = 0;
        send_str("hexp", "0x;", 1'b0, 0);
        expect_token("hexp", 1, T_ERR, 2);

        obs_pulses = 0;
        send_str("dec", "007 ", 1'b0, 0);
        expect_token("dec", 1, T_DEC, 3);

        obs_pulses = 0;
        send_rep("sat33", "a", 33);
        send_str("sat33", " ", 1'b0, 0);
        expect_token("sat33", 1, T_ERR, 32);

        obs_pulses = 0;
        send_rep("len32", "a", 32);
        send_str("len32", " ", 1'b0, 0);
        expect_token("len32", 1, T_IDENT, 32);

        obs_pulses = 0;
        obs_type   = -1;
        obs_len    = -1;
        send_str("rstrun", "abc", 1'b0, 0);
        do_reset("rstrun");
        send_str("rstrun", " ", 1'b0, 0);
        repeat (3) begin
            drive(1'b0, 8'h00, 1'b0);
            check_model("rstrun");
        end
        chk("rstrun pulses", obs_pulses, 0);

        obs_pulses = 0;
        send_str("gaps", "x_9", 1'b1, 2);
        repeat (3) begin
            drive(1'b0, 8'h00, 1'b0);
            check_model("gaps");
        end
        expect_token("gaps", 1, T_IDENT, 3);

        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                send_rep("rnd_long", "b", $urandom_range(30, 34));
            end else if ($urandom_range(0, 599) == 0) begin
                do_reset("rnd");
            end else begin
                drive($urandom_range(0, 99) < 80, rand_char(), $urandom_range(0, 99) < 5);
                check_model("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
